// File: rtl/fu_div_iter.sv
// ---------------------------------------------------------------------------
// fu_div_iter
// Iterative radix-2 restoring divider for the EX stage. One quotient bit is
// resolved per cycle. Latency is fixed for every operand combination,
// including divide-by-zero, so the hazard unit can rely on busy alone.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   EN         start request, only looked at while idle
//   op_signed  1 = two's-complement divide, 0 = unsigned (captured with EN)
//   A, B       dividend / divisor (captured with EN)
//   res, rem   quotient / remainder, updated once per operation, then held
//   div_zero   set with the result when the captured divisor was zero
//   busy       high in every state except IDLE
//   finish     one-cycle pulse while the new result is first presented
//
// State table
//   state | meaning
//   IDLE  | waiting for EN; operands captured on the accepting edge
//   PREP  | take magnitudes, record result signs, clear accumulator/counter
//   CALC  | WIDTH shift/subtract iterations, one per cycle
//   FIX   | apply signs or divide-by-zero result, load output registers
//   DONE  | finish pulse, always back to IDLE
// ---------------------------------------------------------------------------
module fu_div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero,
    output logic             busy,
    output logic             finish
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // raw captured operands; a_q is also the divide-by-zero remainder
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;

    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    // quo_q starts as the dividend magnitude and is shifted out into the
    // accumulator while quotient bits are shifted in from the bottom
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign a_mag = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_mag = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;

    // accumulator is always below the divisor, so the shifted value fits
    // in WIDTH+1 bits and the MSB of trial is a clean borrow indicator
    assign shifted = {acc_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // MIN / -1 needs no special case: |MIN| is MIN as an unsigned value,
    // the quotient comes out as MIN with neg_quo clear and remainder 0
    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        rem_d     = rem_q;
        dz_d      = dz_q;

        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = op_signed;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                quo_d     = a_mag;
                dvs_d     = b_mag;
                acc_d     = '0;
                cnt_d     = '0;
                neg_quo_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = sgn_q & a_q[WIDTH-1];
                state_d   = S_CALC;
            end

            S_CALC: begin
                if (!trial[WIDTH]) begin
                    acc_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (b_q == '0) begin
                    res_d = '1;
                    rem_d = a_q;
                    dz_d  = 1'b1;
                end else begin
                    res_d = quo_fix;
                    rem_d = rem_fix;
                    dz_d  = 1'b0;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_q     <= sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
        end
    end

    assign res      = res_q;
    assign rem      = rem_q;
    assign div_zero = dz_q;
    assign busy     = (state_q != S_IDLE);
    assign finish   = (state_q == S_DONE);

endmodule
